// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch shared constants, fetch-buffer entry type and helpers.
// Constant names mirror the yadan core defines (yadan_defs.v).
package ifu_fetch_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = '0;

  localparam logic RstEnable    = 1'b0;
  localparam logic BranchEnable = 1'b1;
  localparam logic NoStop       = 1'b0;

  typedef struct packed {
    logic [InstAddrBus-1:0] pc;
    logic [InstBus-1:0]     inst;
  } fetch_entry_t;

  localparam int EntryBits = $bits(fetch_entry_t);

  function automatic logic [InstAddrBus-1:0] word_align(
    input logic [InstAddrBus-1:0] a
  );
    return {a[InstAddrBus-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-bus bundle between the fetch unit and instruction memory.
// master = fetch unit, slave = memory side.
import ifu_fetch_pkg::*;

interface ifu_fetch_if;

  logic                   ibus_req_o;
  logic [InstAddrBus-1:0] ibus_addr_o;
  logic                   ibus_gnt_i;
  logic                   ibus_rvalid_i;
  logic [InstBus-1:0]     ibus_rdata_i;

  modport master (
    output ibus_req_o,
    output ibus_addr_o,
    input  ibus_gnt_i,
    input  ibus_rvalid_i,
    input  ibus_rdata_i
  );

  modport slave (
    input  ibus_req_o,
    input  ibus_addr_o,
    output ibus_gnt_i,
    output ibus_rvalid_i,
    output ibus_rdata_i
  );

endinterface

// File: rtl/ifu_fetch_fifo.sv
// ifu_fifo: fetch-buffer storage (push, pop, clear, full, empty).
// DEPTH must be a power of two so the pointers wrap on their own.
import ifu_fetch_pkg::*;

module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = EntryBits
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch with a small buffer.
// Optional macro IFU_MISALIGN_TRAP_EN traps misaligned redirect targets.
import ifu_fetch_pkg::*;

module ifu_fetch #(
  parameter logic [InstAddrBus-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_branch_flag_i,
  input  logic [InstAddrBus-1:0] ex_branch_addr_i,
  input  logic [4:0]             stalled,
  ifu_fetch_if.master            ibus,
  output logic [InstAddrBus-1:0] pc_o,
  output logic [InstBus-1:0]     inst_o,
  output logic                   stallreq_o,
  output logic                   misalign_o
);

  logic [InstAddrBus-1:0] fetch_pc;
  logic [InstAddrBus-1:0] target;
  logic                   outstanding;
  logic                   discard;
  logic                   misalign;
  logic                   redirect;
  logic                   gnt_fire;
  logic                   rsp_fire;
  logic                   in_flight;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  fetch_entry_t           din;
  fetch_entry_t           head;
  logic                   unused_ok;

  assign unused_ok = ^{stalled[4:2], ex_branch_addr_i[1:0]};

  assign redirect = ex_branch_flag_i == BranchEnable;

  assign ibus.ibus_addr_o = fetch_pc;
  assign ibus.ibus_req_o  = (rst != RstEnable)
                         && !outstanding
                         && (stalled[0] == NoStop)
                         && !redirect
                         && !full
                         && !misalign;

  assign gnt_fire = ibus.ibus_req_o && ibus.ibus_gnt_i;
  assign rsp_fire = outstanding && ibus.ibus_rvalid_i;

  // Still owed a response after this edge: it must be swallowed on redirect.
  assign in_flight = (outstanding && !ibus.ibus_rvalid_i) || gnt_fire;

  assign push = rsp_fire && !discard && !redirect;
  assign pop  = !empty && (stalled[1] == NoStop) && !redirect;

  // fetch_pc already stepped past the outstanding request at grant time.
  assign din.pc   = fetch_pc - 32'd4;
  assign din.inst = ibus.ibus_rdata_i;

`ifdef IFU_MISALIGN_TRAP_EN
  assign target = ex_branch_addr_i;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      misalign <= 1'b0;
    end else if (redirect) begin
      misalign <= |ex_branch_addr_i[1:0];
    end
  end
`else
  assign target   = word_align(ex_branch_addr_i);
  assign misalign = 1'b0;
`endif

  assign misalign_o = misalign;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      fetch_pc    <= RESET_PC;
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= target;
      outstanding <= in_flight;
      discard     <= in_flight;
    end else if (gnt_fire) begin
      fetch_pc    <= fetch_pc + 32'd4;
      outstanding <= 1'b1;
    end else if (rsp_fire) begin
      outstanding <= 1'b0;
      discard     <= 1'b0;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EntryBits)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .din   (din),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign pc_o       = empty ? fetch_pc : head.pc;
  assign inst_o     = empty ? ZeroWord : head.inst;
  assign stallreq_o = empty || (rst == RstEnable);

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized scoreboard bench for ifu_fetch with a bus responder model.
// Expected stream: consecutive word addresses from the last redirect target.
import ifu_fetch_pkg::*;

module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ex_branch_flag_i = 1'b0;
  logic [31:0] ex_branch_addr_i = '0;
  logic [4:0]  stalled = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic        misalign_o;

  ifu_fetch_if ibus ();

  ifu_fetch #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_branch_flag_i (ex_branch_flag_i),
    .ex_branch_addr_i (ex_branch_addr_i),
    .stalled          (stalled),
    .ibus             (ibus.master),
    .pc_o             (pc_o),
    .inst_o           (inst_o),
    .stallreq_o       (stallreq_o),
    .misalign_o       (misalign_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int n_consumed = 0;

  // per-cycle stimulus knobs, applied at the next falling edge
  bit          k_rst = 0;
  bit          k_br = 0;
  logic [31:0] k_tgt = '0;
  bit          k_s0 = 0;
  bit          k_s1 = 0;
  int          k_gnt = 100;
  int          k_rv = 100;
  int          k_spur = 0;

  // reference model state
  bit          started = 0;
  bit          pending = 0;
  bit          drop = 0;
  bit          mis = 0;
  int          occ = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] gen_pc = RST_PC;
  exp_t        exp_q[$];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    exp_t e;
    while (exp_q.size() < 16) begin
      e.pc   = gen_pc;
      e.inst = memfn(gen_pc);
      exp_q.push_back(e);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic step();
    bit exp_req;
    bit rsp;
    bit g;
    bit consume;
    @(negedge clk);
    rst              = k_rst;
    ex_branch_flag_i = k_br;
    ex_branch_addr_i = k_tgt;
    stalled          = {3'b000, k_s1, k_s0};
    if (k_rst && pending && int'($urandom_range(99)) < k_rv) begin
      ibus.ibus_rvalid_i = 1'b1;
      ibus.ibus_rdata_i  = memfn(pend_addr);
    end else if (k_rst && !pending && int'($urandom_range(99)) < k_spur) begin
      ibus.ibus_rvalid_i = 1'b1;
      ibus.ibus_rdata_i  = $urandom;
    end else begin
      ibus.ibus_rvalid_i = 1'b0;
      ibus.ibus_rdata_i  = $urandom;
    end
    #1;
    ibus.ibus_gnt_i = int'($urandom_range(99)) < k_gnt;
    #2;
    if (!k_rst) begin
      if (started) begin
        chk("rst_req", ibus.ibus_req_o, 0);
        chk("rst_stallreq", stallreq_o, 1);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_misalign", misalign_o, 0);
      end
      started = 1;
      pending = 0;
      drop    = 0;
      mis     = 0;
      occ     = 0;
      exp_pc  = RST_PC;
      gen_pc  = RST_PC;
      exp_q.delete();
    end else begin
      exp_req = !pending && !k_s0 && !k_br && occ < DEPTH && !mis;
      chk("ibus_req", ibus.ibus_req_o, exp_req);
      if (exp_req) chk("ibus_addr", ibus.ibus_addr_o, exp_pc);
      chk("stallreq", stallreq_o, occ == 0);
      if (occ == 0) begin
        chk("inst_empty", inst_o, ZeroWord);
        chk("pc_empty", pc_o, exp_pc);
      end
      chk("misalign", misalign_o, mis);
      rsp     = ibus.ibus_rvalid_i && pending;
      g       = exp_req && ibus.ibus_gnt_i;
      consume = occ > 0 && !k_s1 && !k_br;
      if (k_br) begin
        drop    = pending && !rsp;
        pending = pending && !rsp;
        occ     = 0;
`ifdef IFU_MISALIGN_TRAP_EN
        exp_pc = k_tgt;
        mis    = k_tgt[1:0] != 2'b00;
`else
        exp_pc = {k_tgt[31:2], 2'b00};
`endif
        exp_q.delete();
        gen_pc = exp_pc;
      end else begin
        if (rsp) begin
          pending = 0;
          if (drop) drop = 0;
          else occ++;
        end
        if (consume) occ--;
        if (g) begin
          pending   = 1;
          pend_addr = exp_pc;
          exp_pc    = exp_pc + 32'd4;
        end
      end
    end
    topup();
  endtask

  // monitor: pops and compares every instruction the decode side consumes
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst && !ex_branch_flag_i && !stalled[1] && !stallreq_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL scoreboard_empty: got pc %h with no expected entry",
                   pc_o);
        end else begin
          e = exp_q.pop_front();
          chk("pc_o", pc_o, e.pc);
          chk("inst_o", inst_o, e.inst);
          n_consumed++;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    ibus.ibus_gnt_i    = 1'b0;
    ibus.ibus_rvalid_i = 1'b0;
    ibus.ibus_rdata_i  = '0;
    repeat (3) step();

    // reset release, gnt tied high, prompt responses
    k_rst = 1;
    first = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (first == 0 && !stallreq_o) first = c;
    end
    chk("first_inst_cycle", first, 3);

    // decode stalled: buffer fills and requests stop
    k_s1 = 1;
    repeat (6) step();
    chk("full_no_req", ibus.ibus_req_o, 0);
    chk("full_presented", stallreq_o, 0);
    k_s1 = 0;
    repeat (6) step();

    // redirect while a request is outstanding
    k_rv = 0;
    for (int i = 0; i < 10 && !pending; i++) step();
    chk("wait_outstanding_c", pending, 1);
    k_br = 1;
    k_tgt = 32'h0000_0100;
    step();
    k_br = 0;
    k_rv = 100;
    repeat (8) step();

    // grant withheld with the buffer drained
    k_gnt = 0;
    repeat (6) step();
    k_gnt = 100;
    repeat (4) step();

    // redirect in the same cycle as the response
    k_rv = 0;
    for (int i = 0; i < 10 && !pending; i++) step();
    chk("wait_outstanding_e", pending, 1);
    k_rv = 100;
    k_br = 1;
    k_tgt = 32'h0000_0200;
    step();
    k_br = 0;
    step();
    chk("flush_same_cycle", stallreq_o, 1);
    repeat (6) step();

    // misaligned redirect target
    k_br = 1;
    k_tgt = 32'h0000_0102;
    step();
    k_br = 0;
    repeat (6) step();
`ifdef IFU_MISALIGN_TRAP_EN
    chk("misalign_set", misalign_o, 1);
    chk("misalign_no_req", ibus.ibus_req_o, 0);
    k_br = 1;
    k_tgt = 32'h0000_0300;
    step();
    k_br = 0;
    repeat (4) step();
`endif

    // randomized traffic, including wrap-around targets
    k_gnt = 60;
    k_rv = 50;
    k_spur = 15;
    for (int i = 0; i < 500; i++) begin
      k_s0 = $urandom_range(9) == 0;
      k_s1 = $urandom_range(3) == 0;
      k_br = $urandom_range(24) == 0;
      k_tgt = $urandom;
      if ($urandom_range(3) != 0) k_tgt[1:0] = 2'b00;
      if ($urandom_range(5) == 0) k_tgt = 32'hFFFF_FFF4;
      step();
    end
    k_s0 = 0;
    k_s1 = 0;
    k_br = 0;
    k_gnt = 100;
    k_rv = 100;
    k_spur = 0;
    repeat (10) step();
    chk("progress", n_consumed >= 40, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, giving the fetch-buffer entries (power of two, 2..4).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (`RstEnable` = 1'b0).
REQ-005 ex_branch_flag_i  input  1  redirect from execute (`BranchEnable`).
REQ-006 ex_branch_addr_i  input  32  redirect target.
REQ-007 stalled  input  5  pipeline stall vector; bit0 freezes request issue, bit1 holds the decode-side consumer.
REQ-008 ibus_req_o  output  1  instruction-bus request.
REQ-009 ibus_addr_o  output  32  request address.
REQ-010 ibus_gnt_i  input  1  request accepted this cycle.
REQ-011 ibus_rvalid_i  input  1  read data valid.
REQ-012 ibus_rdata_i  input  32  read data.
REQ-013 pc_o  output  32  PC of the instruction presented to the IF/ID register.
REQ-014 inst_o  output  32  instruction presented to the IF/ID register.
REQ-015 stallreq_o  output  1  fetch-starvation stall request to the stall controller.
REQ-016 misalign_o  output  1  misaligned-target exception flag (REQ-034 only).

Function
REQ-017 A fetch_pc register SHALL hold the next request address; ibus_addr_o = fetch_pc.
REQ-018 At most one bus request SHALL be outstanding; a request is outstanding from the req&&gnt cycle until the rvalid cycle.
REQ-019 ibus_req_o SHALL be 1 only when no request is outstanding, stalled[0]=0, ex_branch_flag_i=0, and FIFO occupancy plus one is <= FIFO_DEPTH.
REQ-020 On req&&gnt, fetch_pc SHALL advance by 4, wrapping modulo 2^32.
REQ-021 Once asserted, ibus_req_o and ibus_addr_o SHALL stay stable until gnt, unless a redirect occurs.
REQ-022 On rvalid with no discard pending, {request address, ibus_rdata_i} SHALL be pushed to the FIFO.
REQ-023 rvalid SHALL be accepted no earlier than one cycle after gnt; rvalid with nothing outstanding SHALL be ignored.
REQ-024 With the FIFO non-empty, pc_o and inst_o SHALL equal the head entry, and stallreq_o SHALL be 0.
REQ-025 With the FIFO empty, inst_o SHALL be `ZeroWord`, pc_o SHALL be fetch_pc, and stallreq_o SHALL be 1.
REQ-026 The head SHALL pop on a cycle with the FIFO non-empty, stalled[1]=`NoStop`, and no redirect.
REQ-027 Push and pop in the same cycle SHALL leave occupancy unchanged; a push to an empty FIFO SHALL become visible the next cycle.
REQ-028 Redirect (ex_branch_flag_i=1) SHALL have priority over all other events, irrespective of stalled.
REQ-029 On redirect, the FIFO SHALL clear and fetch_pc SHALL load ex_branch_addr_i.
REQ-030 On redirect, an outstanding request, or one granted in the same cycle, SHALL set a discard flag.
REQ-031 The response that clears the discard flag SHALL be dropped, not pushed.
REQ-032 While the discard flag is set, a new request SHALL NOT issue (consequence of REQ-018).

Reset
REQ-033 On rst=0 at a clock edge, the block SHALL set fetch_pc=RESET_PC and clear the FIFO, outstanding flag, discard flag and misalign_o; ibus_req_o=0 and stallreq_o=1 that cycle, and the first request issues the cycle after rst rises.

Configuration
REQ-034 With macro IFU_MISALIGN_TRAP_EN defined, a redirect target with addr[1:0]!=0 SHALL set misalign_o=1 (held until the next redirect or reset) and inhibit requests while set; otherwise misalign_o SHALL be tied 0 and addr[1:0] forced to 0 on redirect.

Structure
REQ-035 `ZeroWord`, `RstEnable`, `BranchEnable`, `NoStop`, `InstAddrBus` and `InstBus` SHALL come from yadan_defs.v.
REQ-036 The FIFO SHALL be a sub-module named ifu_fifo (storage only, with push, pop, clear, full and empty).

Verification
REQ-037 Reset release, gnt tied 1, rvalid one cycle later -> addresses 0x0, 0x4, 0x8, ...; the first instruction appears at pc_o on cycle 3 and stallreq_o falls.
REQ-038 stalled[1]=1 for 5 cycles with data returning -> FIFO fills to 2, ibus_req_o drops, and pc_o/inst_o hold the oldest entry with nothing lost.
REQ-039 Redirect to 0x100 while the 0x8 request is outstanding -> the 0x8 data is dropped, the next request is to 0x100, and pc_o=0x100 follows.
REQ-040 gnt held 0 for 3 cycles -> ibus_addr_o is stable, stallreq_o=1, and inst_o=0.
REQ-041 Redirect and rvalid in the same cycle -> the response is dropped and the FIFO is empty next cycle.
REQ-042 With IFU_MISALIGN_TRAP_EN defined, redirect to 0x102 -> misalign_o=1 and no ibus_req_o; without the macro, fetch is from 0x100.
